core_mem_arbiter: RTL and testbench

Two-into-one arbiter that shares a single core memory port between the fetch requester and the LSU data requester. It sits between the core pipeline and the memory/bus bridge. Requests pass through combinationally, and the arbiter routes each response back to its originator. Data accesses win by default; a streak counter bounds how long fetch can be starved. A request that is presented but not yet granted stays locked to its requester until it is accepted.

---
 rtl/core_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_core_mem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one core memory port between the fetch (I) and the
// data (D) requesters. The request path is combinational. Responses are routed
// back to the owner recorded at acceptance. Data requests win by default, and a
// saturating streak counter bounds how long a waiting fetch can be starved.
// A presented but ungranted request stays locked to its requester until accepted.
module core_mem_arbiter #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 64,
  parameter int STRB_W          = DATA_W / 8,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              g_clk,
  input  logic              g_reset,
  // Fetch requester
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_wen,
  input  logic [STRB_W-1:0] imem_strb,
  input  logic [DATA_W-1:0] imem_wdata,
  output logic              imem_gnt,
  output logic              imem_err,
  output logic [DATA_W-1:0] imem_rdata,
  // Data requester
  input  logic              dmem_req,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_wen,
  input  logic [STRB_W-1:0] dmem_strb,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_gnt,
  output logic              dmem_err,
  output logic [DATA_W-1:0] dmem_rdata,
  // Shared memory port
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [STRB_W-1:0] mem_strb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_err,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int          SW         = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic        SEL_D      = 1'b0;
  localparam logic        SEL_I      = 1'b1;

  logic          sel;
  logic          lock_vld;
  logic          lock_sel;
  logic          rsp_vld;
  logic          rsp_sel;
  logic [SW-1:0] streak;
  logic [SW-1:0] streak_nxt;

  // Select the requester that owns the memory port this cycle.
  always_comb begin
    sel = SEL_D;
    if (lock_vld) begin
      sel = lock_sel;
    end else if (imem_req && !dmem_req) begin
      sel = SEL_I;
    end else if (imem_req && dmem_req && (streak == STREAK_MAX)) begin
      sel = SEL_I;
    end
  end

  // Forward the selected request and steer the grant back to its owner.
  always_comb begin
    if (sel == SEL_I) begin
      mem_req   = imem_req;
      mem_addr  = imem_addr;
      mem_wen   = imem_wen;
      mem_strb  = imem_strb;
      mem_wdata = imem_wdata;
    end else begin
      mem_req   = dmem_req;
      mem_addr  = dmem_addr;
      mem_wen   = dmem_wen;
      mem_strb  = dmem_strb;
      mem_wdata = dmem_wdata;
    end
    imem_gnt = mem_gnt && (sel == SEL_I) && imem_req;
    dmem_gnt = mem_gnt && (sel == SEL_D) && dmem_req;
  end

  // Streak of data acceptances while fetch is waiting; saturates at the limit.
  always_comb begin
    streak_nxt = streak;
    if (!imem_req || imem_gnt) begin
      streak_nxt = '0;
    end else if (dmem_gnt && (streak != STREAK_MAX)) begin
      streak_nxt = streak + 1'b1;
    end
  end

  // Lock, streak and response-owner state.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      lock_vld <= 1'b0;
      lock_sel <= SEL_D;
      rsp_vld  <= 1'b0;
      rsp_sel  <= SEL_D;
      streak   <= '0;
    end else begin
      // A dropped locked request gives mem_req=0, so the lock clears by itself.
      lock_vld <= mem_req && !mem_gnt;
      lock_sel <= sel;
      rsp_vld  <= mem_req && mem_gnt;
      rsp_sel  <= sel;
      streak   <= streak_nxt;
    end
  end

  // Route the response; an error arriving during reset belongs to a dropped transfer.
  always_comb begin
    imem_rdata = mem_rdata;
    dmem_rdata = mem_rdata;
    imem_err   = mem_err && rsp_vld && (rsp_sel == SEL_I) && !g_reset;
    dmem_err   = mem_err && rsp_vld && (rsp_sel == SEL_D) && !g_reset;
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomised bench for core_mem_arbiter with a transaction-level reference model.
module tb_core_mem_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int SW   = 8;
  localparam int MAXS = 4;
  localparam int NONE = 0;
  localparam int OWN_I = 1;
  localparam int OWN_D = 2;

  logic          g_clk = 1'b0;
  logic          g_reset;
  logic          imem_req, imem_wen, imem_gnt, imem_err;
  logic [AW-1:0] imem_addr;
  logic [SW-1:0] imem_strb;
  logic [DW-1:0] imem_wdata, imem_rdata;
  logic          dmem_req, dmem_wen, dmem_gnt, dmem_err;
  logic [AW-1:0] dmem_addr;
  logic [SW-1:0] dmem_strb;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          mem_req, mem_wen, mem_gnt, mem_err;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_strb;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 g_clk = ~g_clk;

  core_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .MAX_DATA_STREAK(MAXS)
  ) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen),
    .imem_strb(imem_strb), .imem_wdata(imem_wdata),
    .imem_gnt(imem_gnt), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds an unaccepted request, how many data wins fetch
  // has sat through, and who owns the response due this cycle.
  int lock_owner = NONE;
  int data_wins  = 0;
  int rsp_owner  = NONE;

  // Requester-side pending transactions (held stable until granted).
  bit            i_pend = 0, d_pend = 0;

  task automatic new_payload(output logic [AW-1:0] a, output logic w,
                             output logic [SW-1:0] s, output logic [DW-1:0] d);
    a = {$urandom, $urandom};
    w = 1'($urandom_range(1));
    s = SW'($urandom_range(255));
    d = {$urandom, $urandom};
  endtask

  task automatic cycle(input int p_i, input int p_d, input int p_gnt, input int p_err,
                       input bit rst, output int got_owner);
    int            owner;
    bit            exp_req, acc;
    logic [AW-1:0] ea;
    logic          ew;
    logic [SW-1:0] es;
    logic [DW-1:0] ed;
    @(negedge g_clk);
    if (!i_pend && $urandom_range(99) < p_i) begin
      i_pend = 1;
      new_payload(imem_addr, imem_wen, imem_strb, imem_wdata);
    end
    if (!d_pend && $urandom_range(99) < p_d) begin
      d_pend = 1;
      new_payload(dmem_addr, dmem_wen, dmem_strb, dmem_wdata);
    end
    imem_req  = i_pend;
    dmem_req  = d_pend;
    mem_gnt   = ($urandom_range(99) < p_gnt);
    mem_err   = ($urandom_range(99) < p_err);
    mem_rdata = {$urandom, $urandom};
    g_reset   = rst;

    if (lock_owner != NONE)                 owner = lock_owner;
    else if (i_pend && !d_pend)             owner = OWN_I;
    else if (i_pend && d_pend && data_wins >= MAXS) owner = OWN_I;
    else                                    owner = OWN_D;
    exp_req = (owner == OWN_I) ? i_pend : d_pend;
    acc     = exp_req && mem_gnt;
    ea = (owner == OWN_I) ? imem_addr  : dmem_addr;
    ew = (owner == OWN_I) ? imem_wen   : dmem_wen;
    es = (owner == OWN_I) ? imem_strb  : dmem_strb;
    ed = (owner == OWN_I) ? imem_wdata : dmem_wdata;

    #1;
    check_eq("mem_req",   64'(mem_req),   64'(exp_req));
    check_eq("mem_addr",  mem_addr,       ea);
    check_eq("mem_wen",   64'(mem_wen),   64'(ew));
    check_eq("mem_strb",  64'(mem_strb),  64'(es));
    check_eq("mem_wdata", mem_wdata,      ed);
    check_eq("imem_gnt",  64'(imem_gnt),  64'(acc && owner == OWN_I));
    check_eq("dmem_gnt",  64'(dmem_gnt),  64'(acc && owner == OWN_D));
    check_eq("imem_err",  64'(imem_err),  64'(mem_err && rsp_owner == OWN_I && !rst));
    check_eq("dmem_err",  64'(dmem_err),  64'(mem_err && rsp_owner == OWN_D && !rst));
    check_eq("imem_rdata", imem_rdata,    mem_rdata);
    check_eq("dmem_rdata", dmem_rdata,    mem_rdata);
    got_owner = imem_gnt ? OWN_I : (dmem_gnt ? OWN_D : NONE);

    // Advance the model across the coming rising edge.
    if (acc && owner == OWN_I) i_pend = 0;
    if (acc && owner == OWN_D) d_pend = 0;
    if (!imem_req)                       data_wins = 0;
    else if (acc && owner == OWN_I)      data_wins = 0;
    else if (acc && owner == OWN_D && data_wins < MAXS) data_wins++;
    lock_owner = (exp_req && !mem_gnt) ? owner : NONE;
    rsp_owner  = acc ? owner : NONE;
    if (rst) begin
      lock_owner = NONE;
      data_wins  = 0;
      rsp_owner  = NONE;
    end
  endtask

  int own;
  int exp_seq [10] = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_I, OWN_D, OWN_D, OWN_D, OWN_D, OWN_I};

  initial begin
    g_reset = 1'b1;
    imem_req = 0; imem_addr = '0; imem_wen = 0; imem_strb = '0; imem_wdata = '0;
    dmem_req = 0; dmem_addr = '0; dmem_wen = 0; dmem_strb = '0; dmem_wdata = '0;
    mem_gnt = 0; mem_err = 0; mem_rdata = '0;
    repeat (3) @(posedge g_clk);

    // Idle after reset: all zero outputs, rdata mirrored.
    cycle(0, 0, 0, 0, 0, own);
    // Single fetch read followed by an error response.
    cycle(100, 0, 100, 0, 0, own);
    check_eq("fetch_gnt", 64'(own), 64'(OWN_I));
    cycle(0, 0, 100, 100, 0, own);
    // Starvation bound with both requesting continuously.
    for (int k = 0; k < 10; k++) begin
      cycle(100, 100, 100, 0, 0, own);
      check_eq("starve_seq", 64'(own), 64'(exp_seq[k]));
    end
    // Drain, then reset with a data response in flight.
    repeat (3) cycle(0, 0, 100, 0, 0, own);
    cycle(0, 100, 100, 0, 0, own);
    check_eq("pre_rst_gnt", 64'(own), 64'(OWN_D));
    cycle(0, 0, 0, 100, 1, own);
    cycle(0, 0, 0, 100, 0, own);
    // Randomised traffic with stalls, errors and occasional reset.
    for (int k = 0; k < 3000; k++) begin
      cycle(40, 50, 60, 30, ($urandom_range(99) == 0), own);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
